// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// LOADER_CHECKSUM_EN adds the CHECK state to the encoding.
package program_loader_pkg;

  localparam int LANE_W = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,
    CHECK   = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Loads big-endian bytes into 32-bit program memory words while holding the CPU.
// Ports: clk, reset (async active-low), Start/WordCount, ByteIn/ByteValid/ByteReady,
// WriteEnable/WriteAddress/WriteData, CpuHold, Done, ChecksumError.
// Build option: LOADER_CHECKSUM_EN appends an XOR checksum byte after the last word.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] WordCount,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  ChecksumError
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_W =
    DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] STRIDE =
    DATA_WIDTH'(BYTES_PER_WORD);
  localparam logic [1:0] LAST_LANE =
    2'(BYTES_PER_WORD - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_W =
    DATA_WIDTH'(1);

  state_t state, nxt;

  logic [DATA_WIDTH-1:0] left;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] word;
  logic [1:0]            lane;
  logic                  last;
  logic                  go;

  assign last = (left == ONE_W);
  assign go = Start &&
    ((state == IDLE) || (state == DONE));

  assign WriteAddress = addr;
  assign WriteData = word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    ByteReady = 1'b0;
    WriteEnable = 1'b0;
    Done = 1'b0;
    CpuHold = 1'b1;
    unique case (state)
      IDLE: begin
        if (Start) begin
          nxt = (WordCount == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        ByteReady = 1'b1;
        if (ByteValid && lane == LAST_LANE) begin
          nxt = WRITE;
        end
      end
      WRITE: begin
        WriteEnable = 1'b1;
        if (last) begin
`ifdef LOADER_CHECKSUM_EN
          nxt = CHECK;
`else
          nxt = DONE;
`endif
        end else begin
          nxt = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        ByteReady = 1'b1;
        if (ByteValid) begin
          nxt = DONE;
        end
      end
`endif
      DONE: begin
        Done = 1'b1;
        CpuHold = 1'b0;
        if (Start) begin
          nxt = (WordCount == '0) ? DONE : COLLECT;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Address stops on the last word so it never passes the top of memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left <= '0;
      addr <= '0;
      word <= '0;
      lane <= '0;
    end else begin
      if (go) begin
        left <= (WordCount > DEPTH_W) ? DEPTH_W : WordCount;
        addr <= '0;
        word <= '0;
        lane <= '0;
      end
      if (state == COLLECT && ByteValid) begin
        word <= {word[DATA_WIDTH-LANE_W-1:0], ByteIn};
        lane <= lane + 2'd1;
      end
      if (state == WRITE) begin
        left <= left - ONE_W;
        if (!last) begin
          addr <= addr + STRIDE;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xsum;
  logic       ck_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xsum <= '0;
      ck_err <= 1'b0;
    end else begin
      if (go) begin
        xsum <= '0;
        ck_err <= 1'b0;
      end
      if (state == COLLECT && ByteValid) begin
        xsum <= xsum ^ ByteIn;
      end
      if (state == CHECK && ByteValid) begin
        ck_err <= (ByteIn != xsum);
      end
    end
  end

  assign ChecksumError = ck_err;
`else
  assign ChecksumError = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, random byte streams
// against a word-level reference model, and hand-written corner sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Done;
  logic        ChecksumError;

  program_loader dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .WordCount(WordCount),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .CpuHold(CpuHold),
    .Done(Done),
    .ChecksumError(ChecksumError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  logic [7:0] feed[$];

  always @(negedge clk) begin
    if (reset && WriteEnable) begin
      wq.push_back({WriteAddress, WriteData});
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int nwords(input int wc);
    return (wc > 32) ? 32 : wc;
  endfunction

  // Append the XOR of the data bytes when the checksum build is active.
  task automatic add_sum(input int nw);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (feed[i]) x ^= feed[i];
    if (nw > 0) feed.push_back(x);
`else
    if (nw < 0) feed.delete();
`endif
  endtask

  task automatic rand_feed(input int wc);
    int nw;
    nw = nwords(wc);
    feed.delete();
    for (int i = 0; i < 4 * nw; i++) begin
      feed.push_back(8'($urandom));
    end
    add_sum(nw);
  endtask

  task automatic do_load(input string nm, input int wc,
                         input int gap, input logic exp_err);
    int nw;
    int idx;
    int budget;
    logic acc;
    logic tog;
    wr_t w;
    nw = nwords(wc);
    idx = 0;
    tog = 1'b0;
    wq.delete();
    Start = 1'b1;
    WordCount = wc;
    step();
    Start = 1'b0;
    budget = 8 * feed.size() + 20;
    while (idx < feed.size() && budget > 0) begin
      ByteIn = feed[idx];
      Start = 1'b0;
      case (gap)
        0: ByteValid = 1'b1;
        1: begin
          tog = ~tog;
          ByteValid = tog;
        end
        default: begin
          ByteValid = 1'($urandom);
          Start = ($urandom_range(7) == 0);
          WordCount = $urandom_range(63);
        end
      endcase
      #1;
      acc = ByteValid && ByteReady;
      step();
      if (acc) idx++;
      budget--;
    end
    ByteValid = 1'b0;
    Start = 1'b0;
    chk({nm, " bytes taken"}, idx, feed.size());
    budget = 10;
    while (!Done && budget > 0) begin
      step();
      budget--;
    end
    chk({nm, " done"}, 32'(Done), 1);
    chk({nm, " cpuhold"}, 32'(CpuHold), 0);
    chk({nm, " ckerr"}, 32'(ChecksumError), 32'(exp_err));
    chk({nm, " writes"}, wq.size(), nw);
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      w = wq[i];
      chk({nm, " addr"}, w.a, 32'(4 * i));
      chk({nm, " data"}, w.d,
          {feed[4*i], feed[4*i+1], feed[4*i+2], feed[4*i+3]});
    end
  endtask

  typedef struct {
    int          wc;
    int          gap;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{2, 0, 2, 32'h04};
    tbl[1] = '{1, 1, 1, 32'h00};
    tbl[2] = '{40, 0, 32, 32'h7C};
    tbl[3] = '{0, 0, 0, 32'h00};
    tbl[4] = '{5, 2, 5, 32'h10};
    tbl[5] = '{32, 1, 32, 32'h7C};
    tbl[6] = '{3, 2, 3, 32'h08};

    reset = 1'b0;
    Start = 1'b0;
    WordCount = '0;
    ByteIn = '0;
    ByteValid = 1'b0;
    #3;
    chk("rst ready", 32'(ByteReady), 0);
    chk("rst we", 32'(WriteEnable), 0);
    chk("rst addr", WriteAddress, 0);
    chk("rst data", WriteData, 0);
    chk("rst done", 32'(Done), 0);
    chk("rst ckerr", 32'(ChecksumError), 0);
    chk("rst hold", 32'(CpuHold), 1);
    step();
    reset = 1'b1;
    step();

    feed = '{8'h20, 8'h08, 8'h00, 8'h05,
             8'h20, 8'h09, 8'h00, 8'h07};
    add_sum(2);
    do_load("two words", 2, 0, 1'b0);
    chk("two w0 addr", wq.size() > 0 ? wq[0].a : 'x, 32'h0);
    chk("two w0 data", wq.size() > 0 ? wq[0].d : 'x, 32'h20080005);
    chk("two w1 addr", wq.size() > 1 ? wq[1].a : 'x, 32'h4);
    chk("two w1 data", wq.size() > 1 ? wq[1].d : 'x, 32'h20090007);

    for (int t = 0; t < 7; t++) begin
      rand_feed(tbl[t].wc);
      do_load($sformatf("vec%0d", t), tbl[t].wc, tbl[t].gap, 1'b0);
      chk($sformatf("vec%0d count", t), wq.size(), tbl[t].exp_n);
      if (tbl[t].exp_n > 0) begin
        chk($sformatf("vec%0d last", t),
            wq.size() > 0 ? wq[wq.size()-1].a : 'x, tbl[t].exp_last);
      end
    end

    wq.delete();
    Start = 1'b1;
    WordCount = 0;
    step();
    Start = 1'b0;
    chk("zero done next", 32'(Done), 1);
    step();
    step();
    chk("zero no write", wq.size(), 0);

    wq.delete();
    Start = 1'b1;
    WordCount = 2;
    step();
    Start = 1'b0;
    ByteValid = 1'b1;
    ByteIn = 8'hAA;
    step();
    ByteIn = 8'hBB;
    step();
    ByteValid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst hold", 32'(CpuHold), 1);
    chk("midrst ready", 32'(ByteReady), 0);
    chk("midrst done", 32'(Done), 0);
    chk("midrst addr", WriteAddress, 0);
    step();
    reset = 1'b1;
    step();
    chk("midrst no write", wq.size(), 0);
    feed = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    add_sum(1);
    do_load("after rst", 1, 0, 1'b0);
    chk("after rst data", wq.size() > 0 ? wq[0].d : 'x, 32'hABCDEF01);

`ifdef LOADER_CHECKSUM_EN
    feed = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    do_load("cksum good", 1, 0, 1'b0);
    feed = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    do_load("cksum bad", 1, 1, 1'b1);
    chk("cksum bad data", wq.size() > 0 ? wq[0].d : 'x, 32'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning program memory depth in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction/address width in bits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  meaning a one-cycle pulse that begins a load.
REQ-006 SHALL have port WordCount  input  DATA_WIDTH  meaning number of words to load, sampled on Start.
REQ-007 SHALL have port ByteIn  input  8  meaning the incoming program byte.
REQ-008 SHALL have port ByteValid  input  1  meaning ByteIn holds a valid byte.
REQ-009 SHALL have port ByteReady  output  1  meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port WriteEnable  output  1  meaning a one-cycle program memory write strobe.
REQ-011 SHALL have port WriteAddress  output  DATA_WIDTH  meaning the byte address of the write, always a multiple of 4.
REQ-012 SHALL have port WriteData  output  DATA_WIDTH  meaning the assembled instruction word.
REQ-013 SHALL have port CpuHold  output  1  meaning the processor is held; high in every state except DONE.
REQ-014 SHALL have ports Done, ChecksumError  output  1 each  meaning load complete, and checksum mismatch.

Function
REQ-015 SHALL implement states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-016 In IDLE, Start SHALL latch min(WordCount, MEMORY_DEPTH) and clear the address and byte counter; count 0 SHALL go to DONE, otherwise to COLLECT.
REQ-017 Start SHALL be ignored in COLLECT, WRITE and CHECK; in DONE it SHALL behave as in IDLE.
REQ-018 ByteReady SHALL be high only in COLLECT (and in CHECK when enabled); a byte is taken at a rising edge with ByteValid and ByteReady both high.
REQ-019 Byte order SHALL be big-endian: 1st byte to WriteData[31:24], 4th byte to [7:0].
REQ-020 After the 4th accepted byte the FSM SHALL enter WRITE for exactly one cycle with WriteEnable=1 and ByteReady=0.
REQ-021 Leaving WRITE, WriteAddress SHALL increase by 4; on the last word the next state SHALL be CHECK (if enabled) or DONE, otherwise COLLECT.
REQ-022 WriteAddress SHALL never exceed 4*(MEMORY_DEPTH-1); the count clamp guarantees no wrap.
REQ-023 WriteData and WriteAddress SHALL stay stable while WriteEnable is high.
REQ-024 DONE SHALL drive Done=1 and CpuHold=0 until the next Start or reset.

Reset
REQ-025 Reset low SHALL immediately force IDLE, ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, Done=0, ChecksumError=0, CpuHold=1.
REQ-026 Reset mid-load SHALL discard the partial word; memory already written is not restored.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte, compare it with the XOR of all loaded bytes, set ChecksumError on mismatch, then enter DONE.
REQ-028 Without LOADER_CHECKSUM_EN, the CHECK state and XOR register SHALL be absent, ChecksumError SHALL be tied 0, and WRITE of the last word SHALL go to DONE.

Structure
REQ-029 A shared package SHALL hold the state encoding, the byte-lane width constant (8), and the bytes-per-word constant (4).
REQ-030 The design SHALL be one module with no sub-modules; the byte assembler is an inline shift register.

Verification
REQ-031 Load 2 words, bytes 20,08,00,05,20,09,00,07, ByteValid always high -> writes 0x20080005 @0x0, then 0x20090007 @0x4, then Done=1, CpuHold=0.
REQ-032 Toggle ByteValid every other cycle during a 1-word load -> the word is assembled correctly and WriteEnable pulses once.
REQ-033 WordCount=40 with MEMORY_DEPTH=32 -> exactly 32 writes, last at 0x7C.
REQ-034 Assert reset after 2 bytes of word 1 -> IDLE, CpuHold=1, no write; a fresh Start then loads from 0x0.
REQ-035 With LOADER_CHECKSUM_EN, load 1 word 0x12345678 then send checksum 0x08 -> ChecksumError=0; send 0x09 -> ChecksumError=1.
REQ-036 Start with WordCount=0 -> DONE on the next cycle with no WriteEnable pulse.
